door_input_cond: RTL and testbench
==================================

DOOR_INPUT_COND -- requirements
Module: door_input_cond

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20000, number of consecutive differing samples needed to accept a new input level (10 ms at 2 MHz); legal range 2..65535.
REQ-002 clk2m  input  1  system clock, 2 MHz, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 key_up_raw  input  1  asynchronous "open" pushbutton, active high, bouncing.
REQ-005 key_down_raw  input  1  asynchronous "close" pushbutton, active high, bouncing.
REQ-006 sense_up_raw  input  1  asynchronous top end-stop switch, active high, bouncing.
REQ-007 sense_down_raw  input  1  asynchronous bottom end-stop switch, active high, bouncing.
REQ-008 key_up  output  1  one-cycle pulse on accepted press of the open key.
REQ-009 key_down  output  1  one-cycle pulse on accepted press of the close key.
REQ-010 sense_up  output  1  debounced top end-stop level.
REQ-011 sense_down  output  1  debounced bottom end-stop level.
REQ-012 sensor_fault  output  1  high while both debounced end-stops are active.

Function
REQ-013 Each raw input SHALL pass through a 2-stage flip-flop synchronizer before any other logic.
REQ-014 Each channel SHALL hold a stable level and a counter of width $clog2(DEBOUNCE_CYCLES+1).
REQ-015 Counter behaviour per edge:
- synchronized value differs from stable: counter increments.
- synchronized value equals stable: counter clears to 0.
REQ-016 When a differing sample arrives with counter == DEBOUNCE_CYCLES-1, the stable level SHALL take the synchronized value and the counter SHALL clear, so exactly DEBOUNCE_CYCLES consecutive differing samples are required.
REQ-017 All outputs SHALL be registered, one edge after the stable level.
- Latency from a clean raw transition to the output response: DEBOUNCE_CYCLES+3 rising edges.
REQ-018 key_up SHALL pulse high for exactly one cycle when stable key_up rises while stable key_down is low.
- key_down is symmetric.
REQ-019 Both keys SHALL be suppressed in these cases:
- Both stable keys rise on the same edge: neither pulse.
- One key rises while the other stable key is high: no pulse.
- key_up and key_down SHALL never be high in the same cycle.
REQ-020 Holding a key SHALL produce no further pulses; a new pulse requires stable release and re-press.
REQ-021 Stable key falling edges SHALL produce no output.
REQ-022 sense_up / sense_down SHALL follow the stable levels while they are not both high.
REQ-023 When both stable sensor levels are high:
- sense_up and sense_down SHALL output 0 and sensor_fault SHALL output 1.
- Normal outputs SHALL resume one edge after either stable level drops.
REQ-024 A glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL cause no output change.

Reset
REQ-025 While rst_n is low, all synchronizer flops, stable levels, counters and outputs SHALL be 0, regardless of clock.
REQ-026 Reset asserted mid-debounce SHALL discard the partial count.
- After release, an input held high SHALL be accepted after DEBOUNCE_CYCLES+3 edges.
- Keys already held high through reset SHALL produce one press pulse after that latency.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-027 key_up_raw 0->1 held -> key_up high for exactly one cycle, 7 edges after the input change; no further pulse while held.
REQ-028 key_up_raw toggling every 2 cycles for 20 cycles, then held 0 -> key_up never asserts and the stable level stays 0.
REQ-029 key_up_raw and key_down_raw rise on the same edge -> both outputs stay 0; release both, then press key_down alone -> single key_down pulse.
REQ-030 sense_up_raw=1 and sense_down_raw=1 held -> after 7 edges sense_up=0, sense_down=0, sensor_fault=1; drop sense_down_raw -> 7 edges later sense_up=1, sensor_fault=0.
REQ-031 rst_n pulsed low after 2 debounce counts on sense_down_raw=1 -> all outputs 0 immediately; sense_down=1 exactly 7 edges after rst_n release.

Source files
------------

// File: rtl/door_input_cond.sv
// rtl/door_input_cond.sv - door pushbutton and end-stop input conditioning
// Synchronizes, debounces and decodes two keys and two end-stop switches.
module door_input_cond #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk2m,
  input  logic rst_n,
  input  logic key_up_raw,
  input  logic key_down_raw,
  input  logic sense_up_raw,
  input  logic sense_down_raw,
  output logic key_up,
  output logic key_down,
  output logic sense_up,
  output logic sense_down,
  output logic sensor_fault
);

  localparam int NCH = 4;
  localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Channel order: 0 key_up, 1 key_down, 2 sense_up, 3 sense_down
  logic [NCH-1:0]         raw;
  logic [NCH-1:0]         sync1_q, sync1_d;
  logic [NCH-1:0]         sync2_q, sync2_d;
  logic [NCH-1:0]         stable_q, stable_d;
  logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0]             key_prev_q, key_prev_d;
  logic                   key_up_q, key_up_d;
  logic                   key_down_q, key_down_d;
  logic                   sense_up_q, sense_up_d;
  logic                   sense_down_q, sense_down_d;
  logic                   sensor_fault_q, sensor_fault_d;

  assign raw = {sense_down_raw, sense_up_raw, key_down_raw, key_up_raw};

  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < NCH; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end

    // A key press only counts while the opposite key is released; this also
    // rejects simultaneous rises and keeps the two pulses mutually exclusive.
    key_prev_d     = stable_q[1:0];
    key_up_d       = stable_q[0] & ~key_prev_q[0] & ~stable_q[1];
    key_down_d     = stable_q[1] & ~key_prev_q[1] & ~stable_q[0];
    sense_up_d     = stable_q[2] & ~stable_q[3];
    sense_down_d   = stable_q[3] & ~stable_q[2];
    sensor_fault_d = stable_q[2] & stable_q[3];
  end

  always_ff @(posedge clk2m or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      stable_q       <= '0;
      cnt_q          <= '0;
      key_prev_q     <= '0;
      key_up_q       <= 1'b0;
      key_down_q     <= 1'b0;
      sense_up_q     <= 1'b0;
      sense_down_q   <= 1'b0;
      sensor_fault_q <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      stable_q       <= stable_d;
      cnt_q          <= cnt_d;
      key_prev_q     <= key_prev_d;
      key_up_q       <= key_up_d;
      key_down_q     <= key_down_d;
      sense_up_q     <= sense_up_d;
      sense_down_q   <= sense_down_d;
      sensor_fault_q <= sensor_fault_d;
    end
  end

  assign key_up       = key_up_q;
  assign key_down     = key_down_q;
  assign sense_up     = sense_up_q;
  assign sense_down   = sense_down_q;
  assign sensor_fault = sensor_fault_q;

endmodule

// File: tb/tb_door_input_cond.sv
// tb/tb_door_input_cond.sv - bench for door_input_cond
// Directed scenarios plus random stimulus against a sample-window reference model.
`timescale 1ns/1ps
module tb_door_input_cond;

  localparam int N = 4;

  logic clk2m = 1'b0;
  logic rst_n = 1'b0;
  logic key_up_raw = 1'b0;
  logic key_down_raw = 1'b0;
  logic sense_up_raw = 1'b0;
  logic sense_down_raw = 1'b0;
  logic key_up, key_down, sense_up, sense_down, sensor_fault;

  int vectors = 0;
  int miscompares = 0;
  int pulses_up = 0;
  int pulses_down = 0;

  // Reference model: raw inputs delayed two edges, then a level is accepted once
  // the last N delayed samples all disagree with the current accepted level.
  logic [3:0] dly_q[$];
  logic [3:0] win_q[$];
  logic [3:0] st_m;
  logic [3:0] st_prev_m;
  logic [4:0] exp_o;

  always #250 clk2m = ~clk2m;

  door_input_cond #(.DEBOUNCE_CYCLES(N)) dut (
    .clk2m         (clk2m),
    .rst_n         (rst_n),
    .key_up_raw    (key_up_raw),
    .key_down_raw  (key_down_raw),
    .sense_up_raw  (sense_up_raw),
    .sense_down_raw(sense_down_raw),
    .key_up        (key_up),
    .key_down      (key_down),
    .sense_up      (sense_up),
    .sense_down    (sense_down),
    .sensor_fault  (sensor_fault)
  );

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    dly_q = '{4'b0000, 4'b0000};
    win_q.delete();
    st_m = '0;
    st_prev_m = '0;
    exp_o = '0;
  endtask

  task automatic model_edge(input logic [3:0] applied);
    logic [3:0] samp;
    logic [3:0] nxt;
    logic all_diff;
    exp_o[0] = st_m[0] & ~st_prev_m[0] & ~st_m[1];
    exp_o[1] = st_m[1] & ~st_prev_m[1] & ~st_m[0];
    exp_o[2] = st_m[2] & ~st_m[3];
    exp_o[3] = st_m[3] & ~st_m[2];
    exp_o[4] = st_m[2] & st_m[3];
    dly_q.push_back(applied);
    samp = dly_q.pop_front();
    win_q.push_back(samp);
    if (win_q.size() > N) void'(win_q.pop_front());
    nxt = st_m;
    if (win_q.size() == N) begin
      for (int c = 0; c < 4; c++) begin
        all_diff = 1'b1;
        foreach (win_q[k]) if (win_q[k][c] == st_m[c]) all_diff = 1'b0;
        if (all_diff) nxt[c] = ~st_m[c];
      end
    end
    st_prev_m = st_m;
    st_m = nxt;
  endtask

  task automatic check_outputs();
    cmp("key_up", key_up, exp_o[0]);
    cmp("key_down", key_down, exp_o[1]);
    cmp("sense_up", sense_up, exp_o[2]);
    cmp("sense_down", sense_down, exp_o[3]);
    cmp("sensor_fault", sensor_fault, exp_o[4]);
    cmp("key_exclusive", key_up & key_down, 0);
    if (key_up === 1'b1) pulses_up++;
    if (key_down === 1'b1) pulses_down++;
  endtask

  task automatic step(input logic [3:0] v);
    {sense_down_raw, sense_up_raw, key_down_raw, key_up_raw} = v;
    @(posedge clk2m);
    model_edge(v);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    cmp("reset_key_up", key_up, 0);
    cmp("reset_key_down", key_down, 0);
    cmp("reset_sense_up", sense_up, 0);
    cmp("reset_sense_down", sense_down, 0);
    cmp("reset_sensor_fault", sensor_fault, 0);
    repeat (2) @(posedge clk2m);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  initial begin
    int first;
    logic [3:0] v;
    model_reset();

    // Reset state
    do_reset();

    // Single open press: one pulse, 7 edges after the change, none while held
    pulses_up = 0;
    first = 0;
    for (int i = 1; i <= 16; i++) begin
      step(4'b0001);
      if (key_up === 1'b1 && first == 0) first = i;
    end
    cmp("press_latency", first, 7);
    cmp("press_pulse_count", pulses_up, 1);
    for (int i = 0; i < 10; i++) step(4'b0000);

    // Bouncing key toggling every 2 cycles never accepted
    pulses_up = 0;
    for (int i = 0; i < 20; i++) step(((i / 2) % 2 == 0) ? 4'b0001 : 4'b0000);
    for (int i = 0; i < 10; i++) step(4'b0000);
    cmp("bounce_pulses", pulses_up, 0);

    // Simultaneous press suppressed, then close key alone pulses once
    pulses_up = 0;
    pulses_down = 0;
    for (int i = 0; i < 12; i++) step(4'b0011);
    cmp("both_up_pulses", pulses_up, 0);
    cmp("both_down_pulses", pulses_down, 0);
    for (int i = 0; i < 12; i++) step(4'b0000);
    for (int i = 0; i < 12; i++) step(4'b0010);
    cmp("close_alone_down", pulses_down, 1);
    cmp("close_alone_up", pulses_up, 0);
    for (int i = 0; i < 10; i++) step(4'b0000);

    // Both end-stops active, then bottom released
    for (int i = 1; i <= 7; i++) step(4'b1100);
    cmp("fault_sense_up", sense_up, 0);
    cmp("fault_sense_down", sense_down, 0);
    cmp("fault_flag", sensor_fault, 1);
    for (int i = 1; i <= 7; i++) begin
      step(4'b0100);
      if (i == 6) cmp("fault_hold_6", sensor_fault, 1);
    end
    cmp("recover_sense_up", sense_up, 1);
    cmp("recover_fault", sensor_fault, 0);
    for (int i = 0; i < 10; i++) step(4'b0000);

    // Reset mid-debounce discards partial count
    for (int i = 0; i < 4; i++) step(4'b1000);
    do_reset();
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      step(4'b1000);
      if (sense_down === 1'b1 && first == 0) first = i;
    end
    cmp("reset_release_latency", first, 7);
    for (int i = 0; i < 10; i++) step(4'b0000);

    // Random slowly-changing inputs with occasional resets
    v = 4'b0000;
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < 4; c++) if ($urandom_range(0, 7) == 0) v[c] = ~v[c];
      if ($urandom_range(0, 249) == 0) do_reset();
      step(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
